// File: rtl/two_ops_acc_pkg.sv
// Shared types and default sizing for the two_ops_acc window accumulator.
package two_ops_acc_pkg;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned DefaultNsamp = 4;

    typedef enum logic {
        Accum = 1'b0,
        Hold  = 1'b1
    } acc_state_e;

endpackage

// File: rtl/two_ops_acc_add_cout.sv
// WIDTH-bit adder exposing the carry-out used for the sticky overflow flag.
module add_cout #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/two_ops_acc.sv
// Accumulates NSAMP accepted samples into a modulo-2^WIDTH sum with a sticky carry flag,
// then holds the result until the downstream handshake.
module two_ops_acc
    import two_ops_acc_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned NSAMP = DefaultNsamp
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic [WIDTH-1:0] I,
    input  logic             I_VALID,
    output logic             I_READY,
    input  logic             CLR,
    output logic [WIDTH-1:0] O,
    output logic             OVF,
    output logic             O_VALID,
    input  logic             O_READY,
    output logic [7:0]       CNT
);

    localparam logic [7:0] LastCnt = 8'(NSAMP - 1);

    acc_state_e       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] sum;
    logic             carry;

    add_cout #(
        .WIDTH(WIDTH)
    ) u_add (
        .a   (acc_q),
        .b   (I),
        .sum (sum),
        .cout(carry)
    );

    // Handshake flags are decoded from state and CLR only, never from the valid/ready inputs.
    assign I_READY = (state_q == Accum) && !CLR;
    assign O_VALID = (state_q == Hold);
    assign O       = acc_q;
    assign OVF     = ovf_q;
    assign CNT     = cnt_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        if (CLR) begin
            state_d = Accum;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                Accum: begin
                    if (I_VALID) begin
                        acc_d = sum;
                        ovf_d = ovf_q | carry;
                        cnt_d = cnt_q + 8'd1;
                        if (cnt_q == LastCnt) begin
                            state_d = Hold;
                        end
                    end
                end
                Hold: begin
                    if (O_READY) begin
                        state_d = Accum;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        cnt_d   = '0;
                    end
                end
                default: state_d = Accum;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q <= Accum;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_two_ops_acc.sv
// Self-checking bench for two_ops_acc: directed window scenarios plus randomized traffic.
module tb_two_ops_acc;

    localparam int W = 8;
    localparam int N = 4;

    logic         CLK = 1'b0;
    logic         ASYNCRESETN = 1'b0;
    logic [W-1:0] I = '0;
    logic         I_VALID = 1'b0;
    logic         I_READY;
    logic         CLR = 1'b0;
    logic [W-1:0] O;
    logic         OVF;
    logic         O_VALID;
    logic         O_READY = 1'b0;
    logic [7:0]   CNT;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: window sum as a plain integer, sticky carry, sample count, holding flag.
    int m_acc = 0;
    bit m_ovf = 0;
    int m_cnt = 0;
    bit m_hold = 0;

    two_ops_acc #(
        .WIDTH(W),
        .NSAMP(N)
    ) dut (
        .CLK        (CLK),
        .ASYNCRESETN(ASYNCRESETN),
        .I          (I),
        .I_VALID    (I_VALID),
        .I_READY    (I_READY),
        .CLR        (CLR),
        .O          (O),
        .OVF        (OVF),
        .O_VALID    (O_VALID),
        .O_READY    (O_READY),
        .CNT        (CNT)
    );

    always #5 CLK = ~CLK;

    task automatic model_clear();
        m_acc  = 0;
        m_ovf  = 0;
        m_cnt  = 0;
        m_hold = 0;
    endtask

    task automatic clock_cycle(input logic [W-1:0] i, input logic iv, input logic ordy,
                               input logic clr);
        I       = i;
        I_VALID = iv;
        O_READY = ordy;
        CLR     = clr;
        @(posedge CLK);
        if (clr) begin
            model_clear();
        end else if (!m_hold) begin
            if (iv) begin
                m_acc = m_acc + int'(i);
                if (m_acc >= (1 << W)) begin
                    m_ovf = 1;
                    m_acc = m_acc - (1 << W);
                end
                m_cnt++;
                if (m_cnt == N) m_hold = 1;
            end
        end else if (ordy) begin
            model_clear();
        end
        #1;
    endtask

    task automatic test_reset();
        #1;
        n_vec++;
        if (O !== 8'h00 || OVF !== 1'b0 || CNT !== 8'd0 || O_VALID !== 1'b0 || I_READY !== 1'b1)
        begin
            n_err++;
            $display("FAIL reset: O=%h OVF=%b CNT=%0d O_VALID=%b I_READY=%b, want 00 0 0 0 1",
                     O, OVF, CNT, O_VALID, I_READY);
        end
        #11;
        ASYNCRESETN = 1'b1;
    endtask

    task automatic test_basic_window();
        logic [W-1:0] s [4] = '{8'h10, 8'h20, 8'h30, 8'h40};
        clock_cycle(8'h00, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            clock_cycle(s[k], 1'b1, 1'b0, 1'b0);
            if (k == 2) begin
                n_vec++;
                if (O_VALID !== 1'b0) begin
                    n_err++;
                    $display("FAIL basic_early_valid: O_VALID=%b want 0", O_VALID);
                end
            end
        end
        n_vec++;
        if (O_VALID !== 1'b1 || O !== 8'hA0 || OVF !== 1'b0 || CNT !== 8'd4) begin
            n_err++;
            $display("FAIL basic_window: O_VALID=%b O=%h OVF=%b CNT=%0d, want 1 a0 0 4",
                     O_VALID, O, OVF, CNT);
        end
        clock_cycle(8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_carry();
        logic [W-1:0] s [4] = '{8'hF0, 8'h20, 8'h01, 8'h01};
        for (int k = 0; k < 4; k++) clock_cycle(s[k], 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (O !== 8'h12 || OVF !== 1'b1 || O_VALID !== 1'b1) begin
            n_err++;
            $display("FAIL carry_sum: O=%h OVF=%b O_VALID=%b, want 12 1 1", O, OVF, O_VALID);
        end
        for (int k = 0; k < 2; k++) begin
            clock_cycle(8'h00, 1'b0, 1'b0, 1'b0);
            n_vec++;
            if (OVF !== 1'b1) begin
                n_err++;
                $display("FAIL carry_sticky: OVF=%b want 1", OVF);
            end
        end
        clock_cycle(8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] s [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int k = 0; k < 4; k++) clock_cycle(s[k], 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            clock_cycle(8'h55, 1'b1, 1'b0, 1'b0);
            n_vec++;
            if (O !== 8'hAA || OVF !== 1'b0 || CNT !== 8'd4 || I_READY !== 1'b0) begin
                n_err++;
                $display("FAIL backpressure_hold: O=%h OVF=%b CNT=%0d I_READY=%b, want aa 0 4 0",
                         O, OVF, CNT, I_READY);
            end
        end
        clock_cycle(8'h55, 1'b1, 1'b1, 1'b0);
        n_vec++;
        if (O !== 8'h00 || CNT !== 8'd0 || O_VALID !== 1'b0 || I_READY !== 1'b1) begin
            n_err++;
            $display("FAIL handshake: O=%h CNT=%0d O_VALID=%b I_READY=%b, want 00 0 0 1",
                     O, CNT, O_VALID, I_READY);
        end
        clock_cycle(8'h07, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (O !== 8'h07 || CNT !== 8'd1) begin
            n_err++;
            $display("FAIL post_handshake_accept: O=%h CNT=%0d, want 07 1", O, CNT);
        end
        clock_cycle(8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_clr_collision();
        logic [W-1:0] s [4] = '{8'h04, 8'h05, 8'h06, 8'h07};
        clock_cycle(8'h01, 1'b1, 1'b0, 1'b0);
        clock_cycle(8'h02, 1'b1, 1'b0, 1'b0);
        I = 8'h03;
        I_VALID = 1'b1;
        CLR = 1'b1;
        #1;
        n_vec++;
        if (I_READY !== 1'b0) begin
            n_err++;
            $display("FAIL clr_ready: I_READY=%b want 0", I_READY);
        end
        clock_cycle(8'h03, 1'b1, 1'b0, 1'b1);
        n_vec++;
        if (CNT !== 8'd0 || O !== 8'h00) begin
            n_err++;
            $display("FAIL clr_collision: CNT=%0d O=%h, want 0 00", CNT, O);
        end
        for (int k = 0; k < 4; k++) clock_cycle(s[k], 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (O !== 8'h16 || O_VALID !== 1'b1 || CNT !== 8'd4) begin
            n_err++;
            $display("FAIL clr_next_window: O=%h O_VALID=%b CNT=%0d, want 16 1 4", O, O_VALID, CNT);
        end
        clock_cycle(8'h00, 1'b0, 1'b0, 1'b1);
        n_vec++;
        if (O_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL clr_drops_valid: O_VALID=%b want 0", O_VALID);
        end
    endtask

    task automatic test_reset_mid_window();
        for (int k = 0; k < 3; k++) clock_cycle(8'h09, 1'b1, 1'b0, 1'b0);
        I_VALID = 1'b0;
        #2;
        ASYNCRESETN = 1'b0;
        model_clear();
        #1;
        n_vec++;
        if (O !== 8'h00 || OVF !== 1'b0 || CNT !== 8'd0 || O_VALID !== 1'b0 || I_READY !== 1'b1)
        begin
            n_err++;
            $display("FAIL async_reset: O=%h OVF=%b CNT=%0d O_VALID=%b I_READY=%b, want 00 0 0 0 1",
                     O, OVF, CNT, O_VALID, I_READY);
        end
        #2;
        ASYNCRESETN = 1'b1;
        for (int k = 0; k < 4; k++) clock_cycle(8'h01, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (O !== 8'h04 || O_VALID !== 1'b1) begin
            n_err++;
            $display("FAIL reset_recovery: O=%h O_VALID=%b, want 04 1", O, O_VALID);
        end
        clock_cycle(8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [W-1:0] ri;
        logic riv, rordy, rclr;
        for (int k = 0; k < 300; k++) begin
            ri    = W'($urandom);
            riv   = ($urandom_range(0, 3) != 0);
            rordy = ($urandom_range(0, 2) == 0);
            rclr  = ($urandom_range(0, 19) == 0);
            clock_cycle(ri, riv, rordy, rclr);
            n_vec++;
            if (O !== W'(m_acc)) begin
                n_err++;
                $display("FAIL rand_o[%0d]: got %h want %h", k, O, W'(m_acc));
            end
            if (OVF !== m_ovf) begin
                n_err++;
                $display("FAIL rand_ovf[%0d]: got %b want %b", k, OVF, m_ovf);
            end
            if (CNT !== 8'(m_cnt)) begin
                n_err++;
                $display("FAIL rand_cnt[%0d]: got %0d want %0d", k, CNT, m_cnt);
            end
            if (O_VALID !== m_hold) begin
                n_err++;
                $display("FAIL rand_o_valid[%0d]: got %b want %b", k, O_VALID, m_hold);
            end
            if (I_READY !== (!m_hold && !rclr)) begin
                n_err++;
                $display("FAIL rand_i_ready[%0d]: got %b want %b", k, I_READY, !m_hold && !rclr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_window();
        test_carry();
        test_backpressure();
        test_clr_collision();
        test_reset_mid_window();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
